// File: rtl/vga_pkg.sv
// Shared VGA draw-chain constants and the timing bundle passed between overlay stages.
package vga_pkg;

    localparam int unsigned CNT_W           = 11;
    localparam int unsigned RGB_W           = 12;
    localparam int unsigned DEF_SPRITE_W    = 128;
    localparam int unsigned DEF_SPRITE_H    = 128;
    localparam int unsigned DEF_ADDR_W      = 14;
    localparam logic [RGB_W-1:0] DEF_TRANSPARENT = 12'hF0F;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
    } vga_timing_t;

endpackage

// File: rtl/vga_timing_delay.sv
// Fixed-depth shift register for the VGA timing bundle plus a colour word.
module vga_timing_delay
    import vga_pkg::*;
#(
    parameter int unsigned STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  vga_timing_t      timing_in,
    input  logic [RGB_W-1:0] rgb_in,
    output vga_timing_t      timing_out,
    output logic [RGB_W-1:0] rgb_out
);

    vga_timing_t      timing_q [STAGES];
    logic [RGB_W-1:0] rgb_q    [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                timing_q[i] <= '0;
                rgb_q[i]    <= '0;
            end
        end else begin
            timing_q[0] <= timing_in;
            rgb_q[0]    <= rgb_in;
            for (int unsigned i = 1; i < STAGES; i++) begin
                timing_q[i] <= timing_q[i-1];
                rgb_q[i]    <= rgb_q[i-1];
            end
        end
    end

    assign timing_out = timing_q[STAGES-1];
    assign rgb_out    = rgb_q[STAGES-1];

endmodule

// File: rtl/draw_char_sprite.sv
// Overlays one sprite ROM on the VGA stream: window compare, ROM addressing,
// colour keying, with every output delayed by a fixed 3 cycles.
module draw_char_sprite
    import vga_pkg::*;
#(
    parameter int unsigned      SPRITE_W    = DEF_SPRITE_W,
    parameter int unsigned      SPRITE_H    = DEF_SPRITE_H,
    parameter int unsigned      ADDR_W      = DEF_ADDR_W,
    parameter logic [RGB_W-1:0] TRANSPARENT = DEF_TRANSPARENT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  hcount_in,
    input  logic [CNT_W-1:0]  vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [RGB_W-1:0]  rgb_in,
    input  logic [11:0]       xpos,
    input  logic [11:0]       ypos,
    input  logic [RGB_W-1:0]  rgb_pixel,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [CNT_W-1:0]  hcount_out,
    output logic [CNT_W-1:0]  vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [RGB_W-1:0]  rgb_out
);

    localparam int unsigned COL_W = $clog2(SPRITE_W);
    localparam int unsigned ROW_W = $clog2(SPRITE_H);

    logic [11:0]      x_lat, y_lat;
    logic             pos_valid;
    logic [12:0]      x_end, y_end;
    logic [11:0]      col_off, row_off;
    logic             in_win, in_win_q1, in_win_q2;
    vga_timing_t      timing_in, timing_d2;
    logic [RGB_W-1:0] rgb_d2;

    // 13-bit window bounds so a position near 4095 cannot wrap into view.
    assign x_end   = {1'b0, x_lat} + 13'(SPRITE_W);
    assign y_end   = {1'b0, y_lat} + 13'(SPRITE_H);
    assign col_off = {1'b0, hcount_in} - x_lat;
    assign row_off = {1'b0, vcount_in} - y_lat;

    assign in_win = pos_valid
                 && ({2'b0, hcount_in} >= {1'b0, x_lat}) && ({2'b0, hcount_in} < x_end)
                 && ({2'b0, vcount_in} >= {1'b0, y_lat}) && ({2'b0, vcount_in} < y_end)
                 && !hblnk_in && !vblnk_in;

    // Position is captured once per frame; pos_valid keeps the sprite hidden after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_lat     <= '0;
            y_lat     <= '0;
            pos_valid <= 1'b0;
        end else if (hcount_in == '0 && vcount_in == '0) begin
            x_lat     <= xpos;
            y_lat     <= ypos;
            pos_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr <= '0;
            in_win_q1  <= 1'b0;
            in_win_q2  <= 1'b0;
        end else begin
            pixel_addr <= {row_off[ROW_W-1:0], col_off[COL_W-1:0]};
            in_win_q1  <= in_win;
            in_win_q2  <= in_win_q1;
        end
    end

    assign timing_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                         vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

    // Two stages here; the third is the compositing register below.
    vga_timing_delay #(
        .STAGES(2)
    ) u_timing_delay (
        .clk       (clk),
        .rst       (rst),
        .timing_in (timing_in),
        .rgb_in    (rgb_in),
        .timing_out(timing_d2),
        .rgb_out   (rgb_d2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= timing_d2.hcount;
            vcount_out <= timing_d2.vcount;
            hsync_out  <= timing_d2.hsync;
            vsync_out  <= timing_d2.vsync;
            hblnk_out  <= timing_d2.hblnk;
            vblnk_out  <= timing_d2.vblnk;
            rgb_out    <= (in_win_q2 && rgb_pixel != TRANSPARENT) ? rgb_pixel : rgb_d2;
        end
    end

endmodule

// File: tb/tb_draw_char_sprite.sv
// Randomized bench for draw_char_sprite against a frame-level sprite model and a ROM model.
module tb_draw_char_sprite;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos, rgb_pixel;
    logic [13:0] pixel_addr;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [25:0] tim_out;

    always #5 clk = ~clk;

    draw_char_sprite dut (
        .clk       (clk),
        .rst       (rst),
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .hblnk_in  (hblnk_in),
        .vblnk_in  (vblnk_in),
        .rgb_in    (rgb_in),
        .xpos      (xpos),
        .ypos      (ypos),
        .rgb_pixel (rgb_pixel),
        .pixel_addr(pixel_addr),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .hblnk_out (hblnk_out),
        .vblnk_out (vblnk_out),
        .rgb_out   (rgb_out)
    );

    assign tim_out = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out};

    // Image ROM with registered output.
    logic [11:0] rom [16384];
    always @(posedge clk) rgb_pixel <= rom[pixel_addr];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Per-edge history: what was presented and what the picture should show there.
    logic        h_rst  [MAXC];
    logic [25:0] h_tim  [MAXC];
    logic [11:0] h_col  [MAXC];
    logic        h_win  [MAXC];
    logic [13:0] h_addr [MAXC];

    int mx = 0, my = 0;
    bit mvalid = 1'b0;

    task automatic step(input logic r, input int h, input int v, input logic hb,
                        input logic vb, input logic [11:0] bg);
        int off;
        logic [11:0] pix;
        logic win;
        rst       = r;
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = bg;
        @(posedge clk);
        win = !r && mvalid && h >= mx && h < mx + 128 && v >= my && v < my + 128 && !hb && !vb;
        h_rst[cyc]  = r;
        h_tim[cyc]  = {hcount_in, vcount_in, hsync_in, vsync_in, hb, vb};
        h_win[cyc]  = win;
        h_col[cyc]  = bg;
        h_addr[cyc] = '0;
        if (win) begin
            off         = (v - my) * 128 + (h - mx);
            pix         = rom[off];
            h_addr[cyc] = 14'(off);
            h_col[cyc]  = (pix == 12'hF0F) ? bg : pix;
        end
        if (r) begin
            mx = 0; my = 0; mvalid = 1'b0;
        end else if (h == 0 && v == 0) begin
            mx = int'(xpos); my = int'(ypos); mvalid = 1'b1;
        end
        #1;
        cyc++;
    endtask

    function automatic logic [11:0] exp_rgb(input int c);
        if (c < 2 || h_rst[c] || h_rst[c-1] || h_rst[c-2]) return '0;
        return h_col[c-2];
    endfunction

    function automatic logic [25:0] exp_tim(input int c);
        if (c < 2 || h_rst[c] || h_rst[c-1] || h_rst[c-2]) return '0;
        return h_tim[c-2];
    endfunction

    task automatic test_reset();
        int c;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, int'($urandom_range(2047)), int'($urandom_range(2047)), 1'($urandom),
                 1'($urandom), 12'($urandom));
            checks++;
            if (tim_out !== '0 || rgb_out !== '0 || pixel_addr !== '0) begin
                errors++;
                $display("FAIL reset_zero tim=%h rgb=%h addr=%h want all 0",
                         tim_out, rgb_out, pixel_addr);
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, int'($urandom_range(2047)), int'($urandom_range(1, 1023)), 1'($urandom),
                 1'($urandom), 12'($urandom));
            c = cyc - 1;
            checks++;
            if (tim_out !== exp_tim(c) || rgb_out !== exp_rgb(c)) begin
                errors++;
                $display("FAIL reset_release c=%0d tim=%h rgb=%h want tim=%h rgb=%h",
                         c, tim_out, rgb_out, exp_tim(c), exp_rgb(c));
            end
        end
    endtask

    task automatic test_window();
        int c;
        xpos = 12'd100; ypos = 12'd50;
        step(1'b0, 0, 0, 1'b0, 1'b0, 12'($urandom));
        step(1'b0, 100, 50, 1'b0, 1'b0, 12'h111);
        checks++;
        if (pixel_addr !== 14'h0000) begin
            errors++; $display("FAIL window_addr_first got=%h want=0000", pixel_addr);
        end
        step(1'b0, 101, 50, 1'b0, 1'b0, 12'h111);
        step(1'b0, 102, 50, 1'b0, 1'b0, 12'h111);
        checks++;
        if (rgb_out !== 12'h0A5) begin
            errors++; $display("FAIL window_rgb_first got=%h want=0a5", rgb_out);
        end
        step(1'b0, 227, 177, 1'b0, 1'b0, 12'h222);
        checks++;
        if (pixel_addr !== 14'h3FFF) begin
            errors++; $display("FAIL window_addr_last got=%h want=3fff", pixel_addr);
        end
        step(1'b0, 228, 177, 1'b0, 1'b0, 12'h333);
        step(1'b0, 600, 600, 1'b0, 1'b0, 12'h000);
        checks++;
        if (rgb_out !== 12'h3C3) begin
            errors++; $display("FAIL window_rgb_last got=%h want=3c3", rgb_out);
        end
        step(1'b0, 601, 600, 1'b0, 1'b0, 12'h000);
        checks++;
        if (rgb_out !== 12'h333) begin
            errors++; $display("FAIL window_right_edge got=%h want=333", rgb_out);
        end
        for (int i = 0; i < 80; i++) begin
            step(1'b0, int'($urandom_range(90, 240)), int'($urandom_range(40, 190)),
                 $urandom_range(7) == 0, $urandom_range(7) == 0, 12'($urandom));
            c = cyc - 1;
            checks++;
            if (tim_out !== exp_tim(c) || rgb_out !== exp_rgb(c)) begin
                errors++;
                $display("FAIL window_random c=%0d tim=%h rgb=%h want tim=%h rgb=%h",
                         c, tim_out, rgb_out, exp_tim(c), exp_rgb(c));
            end
            if (h_win[c]) begin
                checks++;
                if (pixel_addr !== h_addr[c]) begin
                    errors++;
                    $display("FAIL window_addr c=%0d got=%h want=%h", c, pixel_addr, h_addr[c]);
                end
            end
        end
    endtask

    task automatic test_transparent();
        xpos = 12'd100; ypos = 12'd50;
        step(1'b0, 0, 0, 1'b0, 1'b0, 12'h000);
        step(1'b0, 105, 50, 1'b0, 1'b0, 12'h123);
        step(1'b0, 227, 50, 1'b0, 1'b0, 12'h456);
        step(1'b0, 100, 177, 1'b0, 1'b0, 12'h789);
        checks++;
        if (rgb_out !== 12'h123) begin
            errors++; $display("FAIL transparent_inside got=%h want=123", rgb_out);
        end
        step(1'b0, 600, 600, 1'b0, 1'b0, 12'h000);
        checks++;
        if (rgb_out !== 12'h456) begin
            errors++; $display("FAIL transparent_right_col got=%h want=456", rgb_out);
        end
        step(1'b0, 601, 600, 1'b0, 1'b0, 12'h000);
        checks++;
        if (rgb_out !== 12'h789) begin
            errors++; $display("FAIL transparent_bottom_row got=%h want=789", rgb_out);
        end
    endtask

    task automatic test_pos_change();
        int c;
        xpos = 12'd100; ypos = 12'd50;
        step(1'b0, 0, 0, 1'b0, 1'b0, 12'h000);
        xpos = 12'd300;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, (i < 20) ? 95 + i : 285 + i, 120, 1'b0, 1'b0, 12'($urandom));
            c = cyc - 1;
            checks++;
            if (rgb_out !== exp_rgb(c)) begin
                errors++;
                $display("FAIL pos_hold c=%0d got=%h want=%h", c, rgb_out, exp_rgb(c));
            end
        end
        step(1'b0, 300, 60, 1'b0, 1'b0, 12'hABC);
        step(1'b0, 600, 600, 1'b0, 1'b0, 12'h000);
        step(1'b0, 601, 600, 1'b0, 1'b0, 12'h000);
        checks++;
        if (rgb_out !== 12'hABC) begin
            errors++; $display("FAIL pos_no_tearing got=%h want=abc", rgb_out);
        end
        step(1'b0, 0, 0, 1'b0, 1'b0, 12'h000);
        step(1'b0, 300, 50, 1'b0, 1'b0, 12'hDEF);
        step(1'b0, 600, 600, 1'b0, 1'b0, 12'h000);
        step(1'b0, 601, 600, 1'b0, 1'b0, 12'h000);
        checks++;
        if (rgb_out !== 12'h0A5) begin
            errors++; $display("FAIL pos_new_frame got=%h want=0a5", rgb_out);
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b0, int'($urandom_range(90, 440)), int'($urandom_range(40, 190)),
                 1'b0, 1'b0, 12'($urandom));
            c = cyc - 1;
            checks++;
            if (rgb_out !== exp_rgb(c)) begin
                errors++;
                $display("FAIL pos_moved c=%0d got=%h want=%h", c, rgb_out, exp_rgb(c));
            end
        end
    endtask

    task automatic test_clip();
        int c;
        xpos = 12'd1000; ypos = 12'd0;
        step(1'b0, 0, 0, 1'b0, 1'b0, 12'h000);
        step(1'b0, 1000, 0, 1'b0, 1'b0, 12'h111);
        step(1'b0, 1030, 0, 1'b1, 1'b0, 12'h5A5);
        step(1'b0, 1200, 300, 1'b1, 1'b0, 12'h000);
        checks++;
        if (rgb_out !== 12'h0A5) begin
            errors++; $display("FAIL clip_visible_col0 got=%h want=0a5", rgb_out);
        end
        step(1'b0, 1201, 300, 1'b1, 1'b0, 12'h000);
        checks++;
        if (rgb_out !== 12'h5A5) begin
            errors++; $display("FAIL clip_blanked got=%h want=5a5", rgb_out);
        end
        for (int h = 990; h < 1060; h++) begin
            step(1'b0, h, 10, h >= 1024, 1'b0, 12'($urandom));
            c = cyc - 1;
            checks++;
            if (tim_out !== exp_tim(c) || rgb_out !== exp_rgb(c)) begin
                errors++;
                $display("FAIL clip_row c=%0d tim=%h rgb=%h want tim=%h rgb=%h",
                         c, tim_out, rgb_out, exp_tim(c), exp_rgb(c));
            end
        end
        xpos = 12'd2048;
        step(1'b0, 0, 0, 1'b0, 1'b0, 12'h456);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, int'($urandom_range(1, 2047)), int'($urandom_range(0, 300)),
                 1'b0, 1'b0, 12'h456);
            if (i >= 2) begin
                checks++;
                if (rgb_out !== 12'h456) begin
                    errors++; $display("FAIL clip_offscreen got=%h want=456", rgb_out);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        xpos = 12'd100; ypos = 12'd250;
        step(1'b0, 0, 0, 1'b0, 1'b0, 12'h000);
        for (int h = 140; h < 160; h++) begin
            step(1'b0, h, 300, 1'b0, 1'b0, 12'($urandom));
            c = cyc - 1;
            checks++;
            if (rgb_out !== exp_rgb(c)) begin
                errors++;
                $display("FAIL midreset_before c=%0d got=%h want=%h", c, rgb_out, exp_rgb(c));
            end
        end
        step(1'b1, 160, 300, 1'b0, 1'b0, 12'h777);
        checks++;
        if (tim_out !== '0 || rgb_out !== '0 || pixel_addr !== '0) begin
            errors++;
            $display("FAIL midreset_zero tim=%h rgb=%h addr=%h want all 0",
                     tim_out, rgb_out, pixel_addr);
        end
        step(1'b0, 161, 300, 1'b0, 1'b0, 12'h0F0);
        step(1'b0, 162, 300, 1'b0, 1'b0, 12'h0F1);
        step(1'b0, 163, 300, 1'b0, 1'b0, 12'h0F2);
        checks++;
        if (rgb_out !== 12'h0F0) begin
            errors++; $display("FAIL midreset_background got=%h want=0f0", rgb_out);
        end
        for (int h = 164; h < 180; h++) begin
            step(1'b0, h, 300, 1'b0, 1'b0, 12'($urandom));
            c = cyc - 1;
            checks++;
            if (tim_out !== exp_tim(c) || rgb_out !== exp_rgb(c)) begin
                errors++;
                $display("FAIL midreset_after c=%0d tim=%h rgb=%h want tim=%h rgb=%h",
                         c, tim_out, rgb_out, exp_tim(c), exp_rgb(c));
            end
        end
        step(1'b0, 0, 0, 1'b0, 1'b0, 12'h000);
        step(1'b0, 150, 300, 1'b0, 1'b0, 12'h321);
        step(1'b0, 600, 600, 1'b0, 1'b0, 12'h000);
        step(1'b0, 601, 600, 1'b0, 1'b0, 12'h000);
        checks++;
        if (rgb_out !== 12'h7E1) begin
            errors++; $display("FAIL midreset_next_frame got=%h want=7e1", rgb_out);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 12'($urandom);
        rom[0]              = 12'h0A5;
        rom[5]              = 12'hF0F;
        rom[127]            = 12'hF0F;
        rom[127 * 128]      = 12'hF0F;
        rom[16383]          = 12'h3C3;
        rom[50 * 128 + 50]  = 12'h7E1;
        rst = 1'b1; hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
        xpos = 12'd100; ypos = 12'd50;

        test_reset();
        test_window();
        test_transparent();
        test_pos_change();
        test_clip();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
